dsp_mac_seq: RTL and testbench

DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

---
 rtl/dsp_mac_seq.sv | 103 ++++++++++
 tb/tb_dsp_mac_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: sequences tap operands and opmodes into an external DSP slice and
// captures each N_TAPS-long dot product from its P output.
module dsp_mac_seq #(
    parameter int N_TAPS   = 8,
    parameter int PIPE_LAT = 4,
    parameter int OPM_DLY  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [17:0] s_a,
    input  logic [17:0] s_b,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [17:0] dsp_d,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ce,
    input  logic [47:0] dsp_p,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_data
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;
    localparam int DW = $clog2(PIPE_LAT + 1);
    localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
    localparam logic [7:0] OPM_ACC   = 8'b0000_1001;

    state_t state, state_nxt;
    logic          run;
    logic [7:0]    tap_cnt;
    logic [DW-1:0] drain_cnt;
    logic [7:0]    op_sr [OPM_DLY+1];
    logic [7:0]    opm_issue;
    logic          accept, last_tap, drain_done;

    assign s_ready    = run && (state == IDLE || state == ACCUM);
    assign accept     = s_valid && s_ready;
    assign last_tap   = state == ACCUM && tap_cnt == 8'(N_TAPS - 1);
    assign drain_done = state == DRAIN && drain_cnt == '0;
    assign dsp_d      = '0;
    assign dsp_ce     = rst_n;
    assign dsp_opmode = op_sr[OPM_DLY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Bubbles inside a vector keep Z=P so they add a zero product.
    always_comb begin
        state_nxt = state;
        opm_issue = 8'h00;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ACCUM;
                    opm_issue = OPM_FIRST;
                end
            end
            ACCUM: begin
                opm_issue = OPM_ACC;
                if (accept && last_tap) state_nxt = DRAIN;
            end
            DRAIN: begin
                opm_issue = OPM_ACC;
                if (drain_done) state_nxt = OUTPUT;
            end
            OUTPUT: begin
                if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            dsp_a     <= '0;
            dsp_b     <= '0;
            tap_cnt   <= '0;
            drain_cnt <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            for (int i = 0; i <= OPM_DLY; i++) op_sr[i] <= '0;
        end else begin
            run      <= 1'b1;
            dsp_a    <= accept ? s_a : '0;
            dsp_b    <= accept ? s_b : '0;
            op_sr[0] <= opm_issue;
            for (int i = 1; i <= OPM_DLY; i++) op_sr[i] <= op_sr[i-1];
            if (accept) tap_cnt <= state == IDLE ? 8'd1 : last_tap ? 8'd0 : tap_cnt + 8'd1;
            if (accept && last_tap) drain_cnt <= DW'(PIPE_LAT);
            else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
            if (drain_done) begin
                m_valid <= 1'b1;
                m_data  <= dsp_p;
            end else if (state == OUTPUT && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq: drives dsp_mac_seq against a behavioural DSP slice and checks
// each dot product against a plain sum-of-products reference.
module tb_dsp_mac_seq;
    localparam int N = 4;
    localparam int L = 4;
    localparam int D = 2;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        s_valid = 0;
    logic        s_ready;
    logic [17:0] s_a = 0;
    logic [17:0] s_b = 0;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce;
    logic [47:0] dsp_p;
    logic        m_valid;
    logic        m_ready = 0;
    logic [47:0] m_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [17:0] ta [N];
    logic [17:0] tb [N];

    dsp_mac_seq #(.N_TAPS(N), .PIPE_LAT(L), .OPM_DLY(D)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d),
        .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_p(dsp_p),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    // DSP slice: A/B sampled, multiplied, product reaches P L edges after the
    // operand port; opmode is registered once before the post-adder.
    logic [47:0] p_reg;
    logic [7:0]  opm_q;
    logic [35:0] m_pipe [L-1];
    initial begin
        p_reg = 0;
        opm_q = 0;
        for (int i = 0; i < L - 1; i++) m_pipe[i] = 0;
    end
    always @(posedge clk) begin
        if (dsp_ce) begin
            m_pipe[0] <= 36'(dsp_a) * 36'(dsp_b);
            for (int i = 1; i < L - 1; i++) m_pipe[i] <= m_pipe[i-1];
            opm_q <= dsp_opmode;
            p_reg <= (opm_q[3] ? p_reg : 48'd0) + (opm_q[0] ? 48'(m_pipe[L-2]) : 48'd0);
        end
    end
    assign dsp_p = p_reg;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] ref_sum();
        logic [47:0] s = 0;
        for (int i = 0; i < N; i++) s += 48'(ta[i]) * 48'(tb[i]);
        return s;
    endfunction

    task automatic push(input logic [17:0] a, input logic [17:0] b);
        int n = 0;
        s_valid = 1;
        s_a = a;
        s_b = b;
        while (!s_ready && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 48'(n), 48'd0);
        @(posedge clk);
        @(negedge clk);
        s_valid = 0;
    endtask

    task automatic send_vec(input int gap, input bit rnd);
        for (int i = 0; i < N; i++) begin
            push(ta[i], tb[i]);
            if (i < N - 1) repeat (rnd ? $urandom_range(0, gap) : gap) @(negedge clk);
        end
    endtask

    task automatic get_result(input logic [47:0] exp, input int hold, input bit junk);
        int k = 0;
        if (junk) begin
            s_valid = 1;
            s_a = 18'($urandom);
            s_b = 18'($urandom);
            chk("drain_sready", 48'(s_ready), 48'd0);
        end
        while (!m_valid && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("latency", 48'(k), 48'(L + 1));
        chk("data", m_data, exp);
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 48'(m_valid), 48'd1);
            chk("hold_data", m_data, exp);
            chk("hold_sready", 48'(s_ready), 48'd0);
        end
        s_valid = 0;
        m_ready = 1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 0;
        chk("hs_clear", 48'(m_valid), 48'd0);
        chk("sready_after_hs", 48'(s_ready), 48'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) begin
            s_valid = 1'($urandom);
            s_a = 18'($urandom);
            s_b = 18'($urandom);
            m_ready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("rst_sready", 48'(s_ready), 48'd0);
            chk("rst_dsp_a", 48'(dsp_a), 48'd0);
            chk("rst_dsp_b", 48'(dsp_b), 48'd0);
            chk("rst_dsp_d", 48'(dsp_d), 48'd0);
            chk("rst_opmode", 48'(dsp_opmode), 48'd0);
            chk("rst_ce", 48'(dsp_ce), 48'd0);
            chk("rst_mvalid", 48'(m_valid), 48'd0);
            chk("rst_mdata", m_data, 48'd0);
        end
        s_valid = 0;
        m_ready = 0;
        rst_n = 1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_sready", 48'(s_ready), 48'd1);
        chk("post_rst_ce", 48'(dsp_ce), 48'd1);

        for (int i = 0; i < N; i++) begin
            ta[i] = 18'(2 * i + 1);
            tb[i] = 18'(2 * i + 2);
        end
        send_vec(0, 0);
        get_result(48'd100, 0, 0);
        send_vec(3, 0);
        get_result(48'd100, 0, 0);
        send_vec(0, 0);
        get_result(48'd100, 3, 1);
        for (int i = 0; i < N; i++) begin
            ta[i] = 18'($urandom);
            tb[i] = 18'($urandom);
        end
        send_vec(0, 0);
        get_result(ref_sum(), 0, 0);

        push(18'($urandom), 18'($urandom));
        push(18'($urandom), 18'($urandom));
        rst_n = 0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_mvalid", 48'(m_valid), 48'd0);
        chk("abort_opmode", 48'(dsp_opmode), 48'd0);
        rst_n = 1;
        repeat (L + 3) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_result", 48'(m_valid), 48'd0);
        end
        for (int i = 0; i < N; i++) begin
            ta[i] = 18'd1;
            tb[i] = 18'd1;
        end
        send_vec(0, 0);
        get_result(48'd4, 0, 0);

        for (int i = 0; i < N; i++) begin
            ta[i] = 18'h3FFFF;
            tb[i] = 18'h3FFFF;
        end
        send_vec(1, 0);
        get_result(48'(4 * ((64'd1 << 18) - 1) * ((64'd1 << 18) - 1)), 0, 0);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N; i++) begin
                ta[i] = 18'($urandom);
                tb[i] = 18'($urandom);
            end
            send_vec(3, 1);
            get_result(ref_sum(), $urandom_range(0, 2), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
